// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: drives ClkSel of a glitch-free clock mux (drain, switch, settle, heartbeat verify).
// Build option: define CLKSW_AUTO_REVERT_EN to restore the previous source when verification times out.
module clock_switch_ctrl #(
  parameter logic RESET_SEL      = 1'b0,
  parameter int   SETTLE_CYCLES  = 16,
  parameter int   VERIFY_EDGES   = 4,
  parameter int   TIMEOUT_CYCLES = 1024
) (
  input  logic Clk,
  input  logic nReset,
  input  logic ReqValid,
  input  logic ReqSel,
  output logic ReqReady,
  input  logic Busy,
  input  logic Heartbeat,
  output logic ClkSel,
  output logic CurSel,
  output logic Switching,
  output logic Done,
  output logic Error,
  input  logic ErrorClr
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int EW = $clog2(VERIFY_EDGES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_INIT  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_ONE   = SW'(1);
  localparam logic [EW-1:0] EDGE_ONE     = EW'(1);
  localparam logic [EW-1:0] EDGE_LAST    = EW'(VERIFY_EDGES - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_SWITCH = 3'd2,
    S_VERIFY = 3'd3
`ifdef CLKSW_AUTO_REVERT_EN
    , S_REVERT = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          clk_sel_q, clk_sel_d;
  logic          cur_sel_q, cur_sel_d;
  logic          target_q, target_d;
  logic          req_ready_q, req_ready_d;
  logic          switching_q, switching_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [1:0]    hb_sync_q, hb_sync_d;
  logic          hb_prev_q, hb_prev_d;
  logic          hb_edge;

  // Either polarity of the synchronized heartbeat counts as one edge.
  assign hb_edge = hb_sync_q[1] ^ hb_prev_q;

  always_comb begin
    state_d    = state_q;
    clk_sel_d  = clk_sel_q;
    cur_sel_d  = cur_sel_q;
    target_d   = target_q;
    settle_d   = settle_q;
    edge_cnt_d = edge_cnt_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    error_d    = error_q & ~ErrorClr;
    hb_sync_d  = {hb_sync_q[0], Heartbeat};
    hb_prev_d  = hb_sync_q[1];

    case (state_q)
      S_IDLE: begin
        if (ReqValid && req_ready_q) begin
          target_d = ReqSel;
          if (ReqSel == cur_sel_q) done_d = 1'b1;
          else                     state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!Busy) begin
          clk_sel_d = target_q;
          settle_d  = SETTLE_INIT;
          state_d   = S_SWITCH;
        end
      end
      S_SWITCH: begin
        settle_d = settle_q - SETTLE_ONE;
        if (settle_q == SETTLE_ONE) begin
          edge_cnt_d = '0;
          timeout_d  = '0;
          state_d    = S_VERIFY;
        end
      end
      S_VERIFY: begin
        timeout_d = timeout_q + TIMEOUT_ONE;
        if (hb_edge) edge_cnt_d = edge_cnt_q + EDGE_ONE;
        // A final edge arriving on the timeout cycle still counts as success.
        if (hb_edge && (edge_cnt_q == EDGE_LAST)) begin
          cur_sel_d = target_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
`ifdef CLKSW_AUTO_REVERT_EN
          clk_sel_d = cur_sel_q;
          settle_d  = SETTLE_INIT;
          state_d   = S_REVERT;
`else
          cur_sel_d = target_q;
          state_d   = S_IDLE;
`endif
        end
      end
`ifdef CLKSW_AUTO_REVERT_EN
      S_REVERT: begin
        settle_d = settle_q - SETTLE_ONE;
        if (settle_q == SETTLE_ONE) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    switching_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      clk_sel_q   <= RESET_SEL;
      cur_sel_q   <= RESET_SEL;
      target_q    <= RESET_SEL;
      req_ready_q <= 1'b1;
      switching_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      settle_q    <= '0;
      edge_cnt_q  <= '0;
      timeout_q   <= '0;
      hb_sync_q   <= '0;
      hb_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sel_q   <= clk_sel_d;
      cur_sel_q   <= cur_sel_d;
      target_q    <= target_d;
      req_ready_q <= req_ready_d;
      switching_q <= switching_d;
      done_q      <= done_d;
      error_q     <= error_d;
      settle_q    <= settle_d;
      edge_cnt_q  <= edge_cnt_d;
      timeout_q   <= timeout_d;
      hb_sync_q   <= hb_sync_d;
      hb_prev_q   <= hb_prev_d;
    end
  end

  assign ReqReady  = req_ready_q;
  assign ClkSel    = clk_sel_q;
  assign CurSel    = cur_sel_q;
  assign Switching = switching_q;
  assign Done      = done_q;
  assign Error     = error_q;

endmodule
